// File: rtl/mac4_pkg.sv
// Shared widths and output-stage helpers for the mac4_relu_unit neuron slice.
// Operand, product and sum widths are fixed; the scale slice selects Sum/8 modulo 16.
package mac4_pkg;

  localparam int OPW     = 5;
  localparam int PRW     = 10;
  localparam int SUMW    = 12;
  localparam int OUT_LSB = 3;
  localparam int OUT_MSB = 6;
  localparam int NLANES  = 4;

  typedef logic signed [OPW-1:0]  operand_t;
  typedef logic signed [PRW-1:0]  product_t;
  typedef logic signed [PRW:0]    pair_sum_t;
  typedef logic signed [SUMW-1:0] sum_t;
  typedef logic [OPW-1:0]         result_t;

  // Negative sums clamp to zero; otherwise bits above OUT_MSB are dropped without saturation.
  function automatic result_t relu_scale(input sum_t s);
    if (s[SUMW-1]) begin
      return '0;
    end
    return {1'b0, s[OUT_MSB:OUT_LSB]};
  endfunction

endpackage

// File: rtl/mac4_relu_unit_if.sv
// Operand bus between the upstream controller (master) and the neuron slice (slave).
interface mac4_relu_unit_if;
  import mac4_pkg::*;

  logic                       en_reg;
  logic [NLANES-1:0][OPW-1:0] a;
  logic [NLANES-1:0][OPW-1:0] w;
  result_t                    result;

  modport master (output en_reg, output a, output w, input result);
  modport slave  (input en_reg, input a, input w, output result);

endinterface

// File: rtl/mult5_signed.sv
// Exact 5x5 two's-complement multiplier; the 10-bit product cannot overflow.
module mult5_signed
  import mac4_pkg::*;
(
  input  operand_t a_i,
  input  operand_t w_i,
  output product_t p_o
);

  assign p_o = a_i * w_i;

endmodule

// File: rtl/mac4_relu_unit.sv
// Four-lane signed MAC neuron slice: registered products, adder tree, ReLU and /8 scaling.
// The result is combinational from the product register only, so it holds while en_reg is low.
module mac4_relu_unit
  import mac4_pkg::*;
(
  input logic             clk,
  input logic             rst,
  mac4_relu_unit_if.slave bus
);

  product_t  prod_d [NLANES];
  product_t  prod_q [NLANES];
  pair_sum_t s12;
  pair_sum_t s34;
  sum_t      sum;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    mult5_signed u_mult (
      .a_i (operand_t'(bus.a[i])),
      .w_i (operand_t'(bus.w[i])),
      .p_o (prod_d[i])
    );
  end

  // NOTE: the product bank is a handful of flops, not a memory, so it takes the async
  // reset directly; sequential state always uses non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NLANES; i++) begin
        prod_q[i] <= '0;
      end
    end else if (bus.en_reg) begin
      for (int i = 0; i < NLANES; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  // Explicit sign extension at each tree level keeps every addition width-exact.
  assign s12 = {prod_q[0][PRW-1], prod_q[0]} + {prod_q[1][PRW-1], prod_q[1]};
  assign s34 = {prod_q[2][PRW-1], prod_q[2]} + {prod_q[3][PRW-1], prod_q[3]};
  assign sum = {s12[PRW], s12} + {s34[PRW], s34};

  assign bus.result = relu_scale(sum);

endmodule

// File: tb/tb_mac4_relu_unit.sv
// Scoreboard bench for mac4_relu_unit: expected results are queued as operands are driven
// and popped when the loaded result is sampled one time unit after the clock edge.
module tb_mac4_relu_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mac4_relu_unit_if bus_if ();

  mac4_relu_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int         n_compared   = 0;
  int         n_mismatched = 0;
  logic [4:0] exp_q [$];
  logic [4:0] held;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference neuron computed with plain integers, independent of the RTL slicing.
  function automatic logic [4:0] model(input logic [3:0][4:0] a, input logic [3:0][4:0] w);
    int sum = 0;
    for (int i = 0; i < 4; i++) begin
      sum += int'($signed(a[i])) * int'($signed(w[i]));
    end
    if (sum < 0) return 5'd0;
    return 5'((sum / 8) % 16);
  endfunction

  function automatic logic [4:0] s5(input int v);
    return 5'(v);
  endfunction

  task automatic load(input string tag, input logic [3:0][4:0] a, input logic [3:0][4:0] w);
    @(negedge clk);
    bus_if.a      = a;
    bus_if.w      = w;
    bus_if.en_reg = 1'b1;
    exp_q.push_back(model(a, w));
    @(posedge clk);
    #1;
    held = exp_q.pop_front();
    check(tag, bus_if.result, held);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 4; i++) begin
      bus_if.a[i] = 5'($urandom_range(0, 31));
      bus_if.w[i] = 5'($urandom_range(0, 31));
    end
  endtask

  initial begin
    logic [3:0][4:0] a;
    logic [3:0][4:0] w;

    // Reset held with live operands and enable: result must stay zero.
    bus_if.en_reg = 1'b1;
    bus_if.a      = {s5(7), s5(6), s5(5), s5(4)};
    bus_if.w      = {s5(3), s5(3), s5(3), s5(4)};
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", bus_if.result, 5'd0);

    @(negedge clk);
    bus_if.en_reg = 1'b0;
    rst           = 1'b0;
    @(posedge clk);
    #1;
    check("reset_released", bus_if.result, 5'd0);

    // Directed vectors (lane 0 is the rightmost element).
    load("pos_16",   {s5(0), s5(0), s5(0), s5(4)},   {s5(0), s5(0), s5(0), s5(4)});
    load("acc_58",   {s5(0), s5(0), s5(3), s5(7)},   {s5(0), s5(0), s5(3), s5(7)});
    load("neg_16",   {s5(0), s5(0), s5(0), s5(-4)},  {s5(0), s5(0), s5(0), s5(4)});
    load("neg_1",    {s5(0), s5(0), s5(0), s5(-1)},  {s5(0), s5(0), s5(0), s5(1)});
    load("wrap_1024",{s5(-16), s5(-16), s5(-16), s5(-16)}, {s5(-16), s5(-16), s5(-16), s5(-16)});
    load("sum_127",  {s5(0), s5(2), s5(2), s5(11)},  {s5(0), s5(1), s5(2), s5(11)});

    // Back-to-back random loads at full throughput.
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = 5'($urandom_range(0, 31));
        w[i] = 5'($urandom_range(0, 31));
      end
      load("random", a, w);
    end

    // Load a known nonzero value, then hold with operand churn.
    load("hold_load", {s5(0), s5(0), s5(3), s5(7)}, {s5(0), s5(0), s5(3), s5(7)});
    @(negedge clk);
    bus_if.en_reg = 1'b0;
    for (int k = 0; k < 5; k++) begin
      randomize_ops();
      #1;
      check("hold_comb", bus_if.result, held);
      @(posedge clk);
      #1;
      check("hold_edge", bus_if.result, held);
      @(negedge clk);
    end

    // Asynchronous reset pulse between edges, with enable high and live operands.
    bus_if.en_reg = 1'b1;
    bus_if.a      = {s5(0), s5(0), s5(3), s5(7)};
    bus_if.w      = {s5(0), s5(0), s5(3), s5(7)};
    #1;
    check("pre_async", bus_if.result, held);
    rst = 1'b1;
    #1;
    check("async_rst", bus_if.result, 5'd0);
    // Keep rst high across an edge: the coincident load must be ignored.
    @(posedge clk);
    #1;
    check("rst_edge_ignored", bus_if.result, 5'd0);
    @(negedge clk);
    bus_if.en_reg = 1'b0;
    rst           = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_hold", bus_if.result, 5'd0);

    load("after_rst", {s5(0), s5(0), s5(0), s5(4)}, {s5(0), s5(0), s5(0), s5(4)});

    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
